wash_sequencer: RTL

WASH_SEQUENCER -- requirements
Module: wash_sequencer

---
 rtl/wash_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wash_sequencer.sv
// Washing-machine programme sequencer: steps through enabled phases, counting seconds per phase.
// Latency: start is taken on the next edge; digits are combinational from the remaining-seconds count.
// Backpressure: none; pause is a level hold that freezes all counters while high.
module wash_sequencer #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int PHASE_LEN = 5
) (
  input  logic       cp,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] mask,
  output logic [2:0] shinning,
  output logic       second,
  output logic [7:0] phase_left,
  output logic [5:0] inLeft,
  output logic [5:0] inMiddle,
  output logic [5:0] inRight,
  output logic       running,
  output logic       done
);

  localparam int            PW         = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF   = PW'(CLK_DIV / 2);
  localparam logic [9:0]    PHASE_LEN10 = 10'(PHASE_LEN);
  localparam logic [6:0]    PHASE_LEN7  = 7'(PHASE_LEN);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} stateT;

  stateT         state, stateNext;
  logic [PW-1:0] prescaler, prescalerNext;
  logic [9:0]    remaining, remainingNext;
  logic [6:0]    phaseCnt, phaseCntNext;
  logic [2:0]    shinNext;
  logic [7:0]    leftNext;
  logic [7:0]    clearedLeft;
  logic          doneNext;
  logic          tick;
  logic [11:0]   bcd;

  // Phase index i lives in bit 7-i, so the lowest index is the highest set bit.
  function automatic logic [2:0] lowestIdx(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[7-i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popCount(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, m[i]};
    end
    return c;
  endfunction

  assign tick    = (state == RUN) && (prescaler == PRE_MAX);
  assign running = (state == RUN) || (state == PAUSE);
  assign second  = (state == PAUSE) || ((state == RUN) && (prescaler < PRE_HALF));

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prescaler  <= '0;
      remaining  <= '0;
      phaseCnt   <= '0;
      shinning   <= '0;
      phase_left <= '0;
      done       <= 1'b0;
    end else begin
      state      <= stateNext;
      prescaler  <= prescalerNext;
      remaining  <= remainingNext;
      phaseCnt   <= phaseCntNext;
      shinning   <= shinNext;
      phase_left <= leftNext;
      done       <= doneNext;
    end
  end

  // Next-state and datapath updates; a tick on a RUN cycle completes even if pause is sampled.
  always_comb begin
    stateNext     = state;
    prescalerNext = prescaler;
    remainingNext = remaining;
    phaseCntNext  = phaseCnt;
    shinNext      = shinning;
    leftNext      = phase_left;
    doneNext      = 1'b0;
    clearedLeft   = phase_left & ~(8'h80 >> shinning);
    case (state)
      IDLE, DONE: begin
        if (start && (mask != 8'h00)) begin
          stateNext     = RUN;
          leftNext      = mask;
          shinNext      = lowestIdx(mask);
          remainingNext = PHASE_LEN10 * {6'd0, popCount(mask)};
          phaseCntNext  = PHASE_LEN7;
          prescalerNext = '0;
        end
      end
      RUN: begin
        prescalerNext = tick ? '0 : prescaler + 1'b1;
        if (pause) stateNext = PAUSE;
        if (tick) begin
          remainingNext = remaining - 10'd1;
          phaseCntNext  = phaseCnt - 7'd1;
          if (phaseCnt == 7'd1) begin
            leftNext = clearedLeft;
            if (clearedLeft != 8'h00) begin
              // Earlier phases are already cleared, so the lowest remaining is the next one up.
              shinNext     = lowestIdx(clearedLeft);
              phaseCntNext = PHASE_LEN7;
            end else begin
              stateNext = DONE;
              doneNext  = 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (!pause) stateNext = RUN;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Double-dabble conversion of remaining seconds into three BCD digits.
  always_comb begin
    bcd = '0;
    for (int i = 9; i >= 0; i--) begin
      if (bcd[3:0]  > 4'd4) bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4]  > 4'd4) bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] > 4'd4) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], remaining[i]};
    end
    inLeft   = {2'b00, bcd[11:8]};
    inMiddle = {2'b00, bcd[7:4]};
    inRight  = {2'b00, bcd[3:0]};
  end

endmodule
